// File: rtl/lbi_sched_pkg.sv
// Shared constants and FSM encodings for the LBI matrix-engine scheduler.
package lbi_sched_pkg;

   localparam int NUM_ROW    = 140;
   localparam int COEF_W     = 6;
   localparam int SEED_ROW_W = 96;
   localparam int OUT_BITS   = NUM_ROW * COEF_W;
   localparam int MSG_BITS   = 2 * OUT_BITS;
   localparam int RUN_CNT_W  = 12;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t SETUP  = 3'd1;
   localparam state_t LAUNCH = 3'd2;
   localparam state_t RUN    = 3'd3;
   localparam state_t RESP   = 3'd4;

endpackage

// File: rtl/lbi_rr_arb.sv
// Combinational cyclic-priority pick: first set request at or after ptr.
module lbi_rr_arb
   import lbi_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt_onehot,
   output logic [IW-1:0]   gnt_idx,
   output logic            any
);

   // NREQ is a power of two, so ptr+i wraps around the requesters for free.
   always_comb begin
      logic [IW-1:0] idx;
      idx        = '0;
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = ptr + IW'(i);
         if (!any && req[idx]) begin
            any             = 1'b1;
            gnt_idx         = idx;
            gnt_onehot[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lbi_sched.sv
// Round-robin scheduler/sequencer for the shared Lbimatrix engine.
// Optional watchdog on the engine result enabled by `define LBI_SCHED_TIMEOUT_EN.
module lbi_sched
   import lbi_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int MSGW    = MSG_BITS,
   parameter int OUTW    = OUT_BITS,
   parameter int KEYW    = 4,
   parameter int KEY_LAT = 1,
   parameter int BLANK   = 4,
   parameter int TIMEOUT = 4095
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*MSGW-1:0]     req_msg,
   input  logic [NREQ*KEYW-1:0]     req_key,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [OUTW-1:0]          rsp_data,
   output logic [$clog2(NREQ)-1:0]  rsp_tag,
   output logic                     rsp_err,
   output logic [KEYW-1:0]          eng_keyidx,
   output logic [MSGW-1:0]          eng_msg,
   output logic                     eng_msgvld,
   input  logic [OUTW-1:0]          eng_out,
   input  logic                     eng_outvld,
   output logic                     busy,
   output logic [15:0]              done_cnt
);

   localparam int IW = $clog2(NREQ);
   localparam int KW = (KEY_LAT > 1) ? $clog2(KEY_LAT) : 1;
`ifdef LBI_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   // Without the watchdog the run counter only needs to remember "blanking over".
   localparam logic [RUN_CNT_W-1:0] CNT_CAP = TO_EN ? RUN_CNT_W'(TIMEOUT) : RUN_CNT_W'(BLANK);
   localparam logic [RUN_CNT_W-1:0] BLANK_C = RUN_CNT_W'(BLANK);

   state_t                 state;
   logic [IW-1:0]          ptr;
   logic [IW-1:0]          tag;
   logic [KW-1:0]          key_cnt;
   logic [RUN_CNT_W-1:0]   run_cnt;
   logic [NREQ-1:0]        gnt_onehot;
   logic [IW-1:0]          gnt_idx;
   logic                   any;
   logic                   hit;
   logic [MSGW-1:0]        sel_msg;
   logic [KEYW-1:0]        sel_key;

   lbi_rr_arb #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req        (req_valid),
      .ptr        (ptr),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (any)
   );

   always_comb begin
      sel_msg = '0;
      sel_key = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IW'(i)) begin
            sel_msg = req_msg[i*MSGW +: MSGW];
            sel_key = req_key[i*KEYW +: KEYW];
         end
      end
   end

   // Grant is only offered in IDLE and never while reset is being applied.
   assign req_ready  = (state == IDLE && !reset) ? gnt_onehot : '0;
   assign eng_msgvld = (state == LAUNCH);
   assign rsp_valid  = (state == RESP);
   assign busy       = (state != IDLE);
   assign rsp_tag    = tag;
   assign hit        = eng_outvld && (run_cnt >= BLANK_C);

`ifdef LBI_SCHED_TIMEOUT_EN
   logic err_q;
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         tag        <= '0;
         key_cnt    <= '0;
         run_cnt    <= '0;
         eng_msg    <= '0;
         eng_keyidx <= '0;
         rsp_data   <= '0;
         done_cnt   <= '0;
`ifdef LBI_SCHED_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  eng_msg    <= sel_msg;
                  eng_keyidx <= sel_key;
                  tag        <= gnt_idx;
                  ptr        <= gnt_idx + 1'b1;
                  key_cnt    <= '0;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               if (key_cnt == KW'(KEY_LAT - 1)) begin
                  state <= LAUNCH;
               end else begin
                  key_cnt <= key_cnt + 1'b1;
               end
            end
            LAUNCH: begin
               run_cnt <= '0;
               state   <= RUN;
            end
            RUN: begin
               // A qualifying result takes priority over a watchdog expiry in the same cycle.
               if (hit) begin
                  rsp_data <= eng_out;
`ifdef LBI_SCHED_TIMEOUT_EN
                  err_q    <= 1'b0;
`endif
                  state    <= RESP;
               end
`ifdef LBI_SCHED_TIMEOUT_EN
               else if (run_cnt + 1'b1 == CNT_CAP) begin
                  rsp_data <= '0;
                  err_q    <= 1'b1;
                  state    <= RESP;
               end
`endif
               if (run_cnt != CNT_CAP) begin
                  run_cnt <= run_cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  done_cnt <= done_cnt + 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/lbi_sched.md
# lbi_sched

Request scheduler and sequencer for the shared LBI matrix engine (`Lbimatrix`). It does four things:
- Round-robin arbitrates NREQ requesters.
- Latches the winner's message and key index, and presents the key index to the external seed store.
- Fires the single-cycle engine start, then waits for the engine result.
- Returns the 140×6-bit result with the requester's tag over a valid/ready response port.

It sits between the host-side request fabric and one `Lbimatrix` instance plus its seed ROM.

## Interface
Parameters:
- NREQ, 4, number of requesters (power of 2, 2..8)
- MSGW, 1680, engine message width (left‖right halves)
- OUTW, 840, engine result width (140 rows × 6 bits)
- KEYW, 4, seed-store key index width
- KEY_LAT, 1, seed-store read latency in cycles (≥1)
- BLANK, 4, cycles after launch during which eng_outvld is ignored
- TIMEOUT, 4095, watchdog limit in cycles after launch (12-bit counter)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot grant/accept pulse
- req_msg  in  NREQ*MSGW  flat messages; requester i at [i*MSGW +: MSGW]
- req_key  in  NREQ*KEYW  flat key indices
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  OUTW  captured engine result
- rsp_tag  out  $clog2(NREQ)  index of the served requester
- rsp_err  out  1  watchdog fired; rsp_data is zero
- eng_keyidx  out  KEYW  key index to seed store
- eng_msg  out  MSGW  message to engine (registered)
- eng_msgvld  out  1  engine start, single-cycle pulse
- eng_out  in  OUTW  engine result
- eng_outvld  in  1  engine result valid (level)
- busy  out  1  high in any state except IDLE
- done_cnt  out  16  completed jobs, wraps at 2^16

## Operation
- States: IDLE → SETUP → LAUNCH → RUN → RESP → IDLE.
- **IDLE.** If any req_valid is set, grant the first set index at or after ptr, searching cyclically.
  - Assert req_ready[g] in that same cycle.
  - Latch msg, key and tag=g.
  - Set ptr = (g+1) mod NREQ.
  - Go to SETUP.
  - With no request, stay in IDLE and keep req_ready=0.
- **SETUP.** Drive eng_keyidx from the latched key for KEY_LAT cycles, then go to LAUNCH.
- **LAUNCH.** Assert eng_msgvld=1 for exactly one cycle. Clear the run counter. Go to RUN.
- **RUN.** Increment the run counter each cycle.
  - If eng_outvld=1 and counter ≥ BLANK: capture eng_out into rsp_data, set rsp_err=0, go to RESP.
  - eng_outvld seen while counter < BLANK is stale and ignored.
- **RESP.** Hold rsp_valid=1 and keep rsp_data, rsp_tag and rsp_err stable.
  - On rsp_ready=1, increment done_cnt and go to IDLE.
  - No arbitration happens in that cycle; the next grant comes no earlier than the following cycle.
- eng_msg and eng_keyidx hold the latched values from grant until the next grant.
- A requester that drops req_valid before being granted is simply not served. There is no starvation: every asserted requester is granted within NREQ jobs.

## Timing
- Grant at cycle 0.
- eng_keyidx valid from cycle 1.
- eng_msgvld at cycle KEY_LAT+1.
- rsp_valid no earlier than cycle KEY_LAT+2+BLANK.
- Reset values: all outputs are 0. This covers req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, eng_keyidx, eng_msg, eng_msgvld, busy and done_cnt. ptr=0 and state=IDLE.
- Reset mid-job abandons the job with no response. eng_msgvld is not reasserted. The engine shares the same reset.
- rsp_ready asserted while rsp_valid=0 has no effect.
- rsp_valid and rsp_ready in the same RESP cycle is a transfer: rsp_valid=0 on the next cycle.

## Configuration
- **LBI_SCHED_TIMEOUT_EN defined:**
  - In RUN, if the counter reaches TIMEOUT with no qualifying eng_outvld, go to RESP with rsp_err=1 and rsp_data=0.
  - A simultaneous eng_outvld on that cycle wins, giving a normal response.
  - done_cnt still increments when the error response is accepted.
- **LBI_SCHED_TIMEOUT_EN undefined:**
  - RUN waits indefinitely.
  - rsp_err is tied to 0.
  - The run counter saturates at BLANK.

## Structure
- Package lbi_sched_pkg holds:
  - State enum: IDLE, SETUP, LAUNCH, RUN, RESP.
  - Engine constants: NUM_ROW=140, COEF_W=6, SEED_ROW_W=96.
  - MSGW and OUTW derived from the engine constants.
- Sub-module lbi_rr_arb implements the combinational cyclic priority pick, with inputs req and ptr and outputs gnt_onehot, gnt_idx and any. The pointer register stays in lbi_sched.

## Test plan
- **Single request.** Requester 2 with key 5, KEY_LAT=1, BLANK=4, model returns eng_outvld 10 cycles after launch. Expect:
  - req_ready[2] at cycle 0.
  - eng_keyidx=5 at cycle 1.
  - eng_msgvld at cycle 2.
  - rsp_valid at cycle 13 with rsp_tag=2 and rsp_data equal to the model output.
- **Fairness.** All 4 requesters hold valid for 8 jobs. Expect grant order 0,1,2,3,0,1,2,3 and done_cnt=8.
- **Stale valid.** eng_outvld held high from before the launch. Expect no capture before run counter=4; capture on the first qualifying cycle.
- **Backpressure.** rsp_ready low for 20 cycles in RESP. Expect rsp_data and rsp_tag stable, no new grant, busy=1.
- **Watchdog.** With LBI_SCHED_TIMEOUT_EN and the engine silent, expect rsp_valid 4096 cycles after launch with rsp_err=1 and rsp_data=0.
- **Mid-job reset.** Reset asserted in RUN. Expect all outputs 0 the next cycle, and the next grant goes to requester 0 if it is valid.
